data_memory: RTL and testbench



---
 rtl/data_memory.sv | 45 ++++
 tb/tb_data_memory.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-organised synchronous data RAM for the MIPS memory stage.
// Registered read-before-write port; asynchronous reset clears all storage.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  unused_byte_off;

  // Byte offset is deliberately dropped: misaligned accesses hit the containing word.
  assign word_idx        = addr[ADDR_WIDTH-1:2];
  assign unused_byte_off = ^addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[word_idx] <= din;
    end
  end

  // Non-blocking read samples the pre-write word when wen and ren coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= '0;
    end else if (ren) begin
      dout <= mem[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [9:0]  addr;
  logic [31:0] din;
  logic        wen;
  logic        ren;
  logic [31:0] dout;

  int tests_run = 0;
  int tests_failed = 0;

  data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .wen   (wen),
    .ren   (ren),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expected);
    tests_run++;
    assert (dout === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, dout, expected);
    end
  endtask

  // Drive one operation at the falling edge, let it take effect on the rising edge.
  task automatic cycle(input logic we, input logic re, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    wen  = we;
    ren  = re;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    addr  = '0;
    din   = '0;

    // Asynchronous reset pulse while the clock runs
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async_dout", 32'h0);
    wen  = 1'b1;
    ren  = 1'b1;
    addr = 10'd12;
    din  = 32'h5555_AAAA;
    @(posedge clk);
    #1 check("reset_ignores_edges", 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    cycle(1'b0, 1'b1, 10'd12, 32'h0);
    check("reset_read_addr12", 32'h0);

    // Basic write then read, and hold after ren drops
    cycle(1'b1, 1'b0, 10'd12, 32'hDEAD_BEEF);
    check("write_no_read_dout_held", 32'h0);
    cycle(1'b0, 1'b1, 10'd12, 32'h0);
    check("read_addr12", 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 10'd100, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 10'd100, 32'hFFFF_FFFF);
    check("hold_after_ren_low", 32'hDEAD_BEEF);

    // Second address, no aliasing
    cycle(1'b1, 1'b0, 10'd100, 32'h1234_5678);
    check("write_other_word_hold", 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 10'd100, 32'h0);
    check("read_addr100", 32'h1234_5678);
    cycle(1'b0, 1'b1, 10'd12, 32'h0);
    check("reread_addr12", 32'hDEAD_BEEF);

    // Top word and misaligned accesses
    cycle(1'b1, 1'b0, 10'd1020, 32'hA5A5_A5A5);
    cycle(1'b0, 1'b1, 10'd1023, 32'h0);
    check("read_top_misaligned_1023", 32'hA5A5_A5A5);
    cycle(1'b0, 1'b1, 10'd13, 32'h0);
    check("read_misaligned_13", 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 10'd0, 32'h0);
    check("read_addr0_untouched", 32'h0);

    // No combinational path: ren set up but edge not yet reached
    @(negedge clk);
    ren  = 1'b1;
    addr = 10'd100;
    #1 check("no_comb_path", 32'h0);
    @(posedge clk);
    #1 check("read_after_setup", 32'h1234_5678);

    // Same-edge write and read to the same word: old data returned
    cycle(1'b1, 1'b1, 10'd100, 32'hCAFE_F00D);
    check("rbw_old_data", 32'h1234_5678);
    cycle(1'b0, 1'b1, 10'd100, 32'h0);
    check("rbw_new_data", 32'hCAFE_F00D);

    // Misaligned write lands in the containing word
    cycle(1'b1, 1'b0, 10'd14, 32'h0BAD_F00D);
    cycle(1'b0, 1'b1, 10'd12, 32'h0);
    check("misaligned_write_14", 32'h0BAD_F00D);

    // Reset asserted mid-cycle with a write pending
    @(negedge clk);
    wen  = 1'b1;
    ren  = 1'b0;
    addr = 10'd12;
    din  = 32'h7777_7777;
    #2 reset = 1'b1;
    #1 check("midcycle_reset_dout", 32'h0);
    @(posedge clk);
    #1 check("midcycle_reset_hold", 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wen   = 1'b0;
    cycle(1'b0, 1'b1, 10'd12, 32'h0);
    check("post_reset_addr12", 32'h0);
    cycle(1'b0, 1'b1, 10'd100, 32'h0);
    check("post_reset_addr100", 32'h0);
    cycle(1'b0, 1'b1, 10'd1020, 32'h0);
    check("post_reset_addr1020", 32'h0);

    // Normal operation resumes after reset
    cycle(1'b1, 1'b0, 10'd512, 32'h0102_0304);
    cycle(1'b0, 1'b1, 10'd512, 32'h0);
    check("resume_after_reset", 32'h0102_0304);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
